// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units,
// registered broadcast of the winner's result to the ROB and RS.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int ROB_WIDTH = 64,
    parameter int BR_TAG_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_FU-1:0]           fu_valid,
    input  logic [NUM_FU*32-1:0]        fu_result,
    input  logic [NUM_FU*ROB_WIDTH-1:0] fu_dest_ROB,
    input  logic [NUM_FU*BR_TAG_W-1:0]  fu_br_tag,
    output logic [NUM_FU-1:0]           fu_taken,
    output logic                        cdb_valid,
    output logic [31:0]                 cdb_result,
    output logic [ROB_WIDTH-1:0]        cdb_dest_ROB,
    output logic [BR_TAG_W-1:0]         cdb_br_tag,
    output logic [$clog2(NUM_FU)-1:0]   cdb_src
);

    localparam int SRC_W = $clog2(NUM_FU);

    logic [SRC_W-1:0]     ptr_q;
    logic [SRC_W-1:0]     ptr_d;

    logic                 cdb_valid_q;
    logic                 cdb_valid_d;
    logic [31:0]          cdb_result_q;
    logic [31:0]          cdb_result_d;
    logic [ROB_WIDTH-1:0] cdb_dest_q;
    logic [ROB_WIDTH-1:0] cdb_dest_d;
    logic [BR_TAG_W-1:0]  cdb_tag_q;
    logic [BR_TAG_W-1:0]  cdb_tag_d;
    logic [SRC_W-1:0]     cdb_src_q;
    logic [SRC_W-1:0]     cdb_src_d;

    logic                 grant_found;
    logic                 grant_en;
    logic [SRC_W-1:0]     grant_idx;
    int                   scan_pos;
    logic [SRC_W-1:0]     scan_idx;

    logic [31:0]          sel_result;
    logic [ROB_WIDTH-1:0] sel_dest;
    logic [BR_TAG_W-1:0]  sel_tag;

    // Scan valids from ptr with wrap; first valid unit wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_pos    = 0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            scan_pos = int'(ptr_q) + i;
            if (scan_pos >= NUM_FU) begin
                scan_pos = scan_pos - NUM_FU;
            end
            scan_idx = SRC_W'(scan_pos);
            if (!grant_found && fu_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Grant is suppressed by reset and flush; payload never feeds it
    always_comb begin
        grant_en = grant_found && !flush && !rst;
        fu_taken = '0;
        if (grant_en) begin
            fu_taken[grant_idx] = 1'b1;
        end
    end

    // Route the winner's payload toward the output register
    always_comb begin
        sel_result = '0;
        sel_dest   = '0;
        sel_tag    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                sel_result = fu_result[i*32 +: 32];
                sel_dest   = fu_dest_ROB[i*ROB_WIDTH +: ROB_WIDTH];
                sel_tag    = fu_br_tag[i*BR_TAG_W +: BR_TAG_W];
            end
        end
    end

    // Next pointer and broadcast; payload holds when nothing is granted
    always_comb begin
        ptr_d        = ptr_q;
        cdb_valid_d  = 1'b0;
        cdb_result_d = cdb_result_q;
        cdb_dest_d   = cdb_dest_q;
        cdb_tag_d    = cdb_tag_q;
        cdb_src_d    = cdb_src_q;
        if (grant_en) begin
            if (grant_idx == SRC_W'(NUM_FU - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + SRC_W'(1);
            end
            cdb_valid_d  = 1'b1;
            cdb_result_d = sel_result;
            cdb_dest_d   = sel_dest;
            cdb_tag_d    = sel_tag;
            cdb_src_d    = grant_idx;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_result_q <= '0;
            cdb_dest_q   <= '0;
            cdb_tag_q    <= '0;
            cdb_src_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_result_q <= cdb_result_d;
            cdb_dest_q   <= cdb_dest_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_result   = cdb_result_q;
    assign cdb_dest_ROB = cdb_dest_q;
    assign cdb_br_tag   = cdb_tag_q;
    assign cdb_src      = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: round-robin reference model feeds a
// scoreboard queue; a monitor checks every CDB cycle against it.
module tb_cdb_arbiter;

    localparam int NF = 4;
    localparam int RW = 64;
    localparam int BW = 8;

    typedef struct {
        logic [31:0] res;
        logic [RW-1:0] dest;
        logic [BW-1:0] tag;
        logic [1:0] src;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    logic [NF-1:0] fu_valid;
    logic [NF*32-1:0] fu_result;
    logic [NF*RW-1:0] fu_dest_ROB;
    logic [NF*BW-1:0] fu_br_tag;
    logic [NF-1:0] fu_taken;
    logic cdb_valid;
    logic [31:0] cdb_result;
    logic [RW-1:0] cdb_dest_ROB;
    logic [BW-1:0] cdb_br_tag;
    logic [1:0] cdb_src;

    exp_t sb[$];
    int vectors;
    int miscompares;
    int m_ptr;
    logic [NF-1:0] m_taken;

    cdb_arbiter #(
        .NUM_FU(NF),
        .ROB_WIDTH(RW),
        .BR_TAG_W(BW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .fu_valid(fu_valid),
        .fu_result(fu_result),
        .fu_dest_ROB(fu_dest_ROB),
        .fu_br_tag(fu_br_tag),
        .fu_taken(fu_taken),
        .cdb_valid(cdb_valid),
        .cdb_result(cdb_result),
        .cdb_dest_ROB(cdb_dest_ROB),
        .cdb_br_tag(cdb_br_tag),
        .cdb_src(cdb_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: decide the grant from the round-robin rule
    initial begin
        exp_t e;
        logic [NF-1:0] want;
        int g;
        int idx;
        m_ptr = 0;
        m_taken = '0;
        forever begin
            @(negedge clk);
            want = '0;
            g = 0;
            if (!rst && !flush) begin
                for (int k = 0; k < NF; k++) begin
                    idx = (m_ptr + k) % NF;
                    if (want == 0 && fu_valid[idx]) begin
                        want[idx] = 1'b1;
                        g = idx;
                    end
                end
            end
            vectors++;
            if (fu_taken !== want) begin
                miscompares++;
                $display("FAIL taken t=%0t: got %b want %b", $time, fu_taken, want);
            end
            if (rst) begin
                m_ptr = 0;
            end else if (want != 0) begin
                e.res = fu_result[g*32 +: 32];
                e.dest = fu_dest_ROB[g*RW +: RW];
                e.tag = fu_br_tag[g*BW +: BW];
                e.src = 2'(g);
                sb.push_back(e);
                m_ptr = (g + 1) % NF;
            end
            m_taken = want;
        end
    end

    // Monitor: every cycle, the CDB must match the pending grant or be idle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            vectors++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (cdb_valid !== 1'b1 || cdb_result !== e.res ||
                    cdb_dest_ROB !== e.dest || cdb_br_tag !== e.tag ||
                    cdb_src !== e.src) begin
                    miscompares++;
                    $display("FAIL cdb t=%0t: got v=%b r=%h d=%h tg=%h s=%0d want v=1 r=%h d=%h tg=%h s=%0d",
                             $time, cdb_valid, cdb_result, cdb_dest_ROB, cdb_br_tag, cdb_src,
                             e.res, e.dest, e.tag, e.src);
                end
            end else if (cdb_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL cdb_idle t=%0t: got valid=%b want 0", $time, cdb_valid);
            end
        end
    end

    task automatic set_unit(input int u, input logic v, input logic [31:0] r,
                            input logic [RW-1:0] d, input logic [BW-1:0] t);
        fu_valid[u] = v;
        fu_result[u*32 +: 32] = r;
        fu_dest_ROB[u*RW +: RW] = d;
        fu_br_tag[u*BW +: BW] = t;
    endtask

    task automatic new_payload(input int u, input logic v);
        set_unit(u, v, $urandom, {$urandom, $urandom}, BW'($urandom));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Units just taken present a fresh result if keep bit is set
    task automatic refresh(input logic [NF-1:0] keep);
        for (int u = 0; u < NF; u++) begin
            if (m_taken[u]) new_payload(u, keep[u]);
        end
    endtask

    task automatic check_val(input string name, input logic [RW-1:0] got,
                             input logic [RW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        flush = 1'b0;
        fu_valid = '0;
        fu_result = '0;
        fu_dest_ROB = '0;
        fu_br_tag = '0;
        for (int u = 0; u < NF; u++) new_payload(u, 1'b1);

        // Reset with all units requesting
        step();
        check_val("rst_result", RW'(cdb_result), '0);
        check_val("rst_dest", cdb_dest_ROB, '0);
        check_val("rst_tag", RW'(cdb_br_tag), '0);
        check_val("rst_src", RW'(cdb_src), '0);
        step();
        rst = 1'b0;
        step();
        fu_valid = '0;
        step();

        // Single requester at unit 2
        set_unit(2, 1'b1, 32'hDEAD_BEEF, RW'(5), BW'(3));
        step();
        fu_valid = '0;
        check_val("single_result", RW'(cdb_result), RW'(32'hDEAD_BEEF));
        check_val("single_dest", cdb_dest_ROB, RW'(5));
        check_val("single_src", RW'(cdb_src), RW'(2));

        // Skip idle units from ptr=3
        new_payload(1, 1'b1);
        new_payload(2, 1'b1);
        step();
        refresh('0);
        step();
        refresh('0);
        step();

        // Bring ptr to 0, then full contention for 8 cycles
        new_payload(3, 1'b1);
        step();
        refresh('0);
        for (int u = 0; u < NF; u++) new_payload(u, 1'b1);
        repeat (8) begin
            step();
            refresh('1);
        end
        fu_valid = '0;
        step();

        // Flush at ptr=1
        new_payload(0, 1'b1);
        step();
        fu_valid = '0;
        for (int u = 0; u < NF; u++) new_payload(u, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) begin
            step();
            refresh('0);
        end

        // Unit 3 held while 0..2 win
        new_payload(3, 1'b1);
        step();
        refresh('0);
        for (int u = 0; u < NF; u++) new_payload(u, 1'b1);
        repeat (4) begin
            step();
            refresh('0);
        end
        step();

        // Random traffic with legal hold behaviour
        repeat (3000) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int u = 0; u < NF; u++) begin
                if (m_taken[u] || !fu_valid[u]) begin
                    new_payload(u, $urandom_range(0, 2) != 0);
                end else if ($urandom_range(0, 15) == 0) begin
                    fu_valid[u] = 1'b0;
                end
            end
        end

        rst = 1'b0;
        flush = 1'b0;
        fu_valid = '0;
        repeat (3) step();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
